bin2bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter for the processor's display/output path. It runs the shift-and-add-3 (double-dabble) algorithm one input bit per clock, so one adder bank serves any width. It adds a start/busy/done handshake, a configurable digit count, optional two's-complement input, and overflow detection with saturation. Results are held in registers so downstream 7-segment decoders see stable digits between conversions.

---
 rtl/bin2bcd_seq_if.sv | 34 +++
 rtl/bin2bcd_seq.sv | 145 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a display-path client and the bin2bcd_seq converter.
// The master drives start/binary; the converter (slave) returns status and held digits.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 15,
  parameter int DIGITS = 5
);
  logic                start;
  logic [WIDTH-1:0]    binary;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                neg;
  logic                overflow;

  modport master (
    output start,
    output binary,
    input  busy,
    input  done,
    input  bcd,
    input  neg,
    input  overflow
  );

  modport slave (
    input  start,
    input  binary,
    output busy,
    output done,
    output bcd,
    output neg,
    output overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, with
// optional two's-complement input, sticky overflow detection and all-nines saturation.
module bin2bcd_seq #(
  parameter int WIDTH  = 15,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input logic          clk,
  input logic          rst_n,
  bin2bcd_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};
  localparam logic [BW-1:0] ZERO_DIGITS = {BW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  mag_r;
  logic [BW-1:0]     work_r;
  logic              sign_r;
  logic              sticky_r;
  logic [CW-1:0]     cnt_r;
  logic              busy_r;
  logic              done_r;
  logic [BW-1:0]     bcd_r;
  logic              neg_r;
  logic              overflow_r;

  logic              sign_in_s;
  logic [WIDTH-1:0]  mag_in_s;
  logic [BW-1:0]     adj_s;
  logic [BW-1:0]     work_next_s;
  logic [WIDTH-1:0]  mag_next_s;
  logic              carry_s;
  logic              sticky_next_s;
  logic              neg_next_s;

  function automatic logic [BW-1:0] add3_bank(input logic [BW-1:0] d);
    logic [BW-1:0] r;
    r = d;
    for (int k = 0; k < DIGITS; k++) begin
      if (d[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = d[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = d[4*k +: 4];
      end
    end
    return r;
  endfunction

  // Sign and magnitude of the incoming operand; -2^(WIDTH-1) negates onto itself as unsigned.
  always_comb begin
    sign_in_s = 1'b0;
    mag_in_s  = bus.binary;
    if ((SIGNED != 0) && bus.binary[WIDTH-1]) begin
      sign_in_s = 1'b1;
      mag_in_s  = ~bus.binary + WIDTH'(1);
    end else begin
      sign_in_s = 1'b0;
      mag_in_s  = bus.binary;
    end
  end

  // One double-dabble step: add-3 bank, then shift {digits, mag} left with carry-out capture.
  always_comb begin
    adj_s = add3_bank(work_r);
    {carry_s, work_next_s, mag_next_s} = {adj_s, mag_r, 1'b0};
    sticky_next_s = sticky_r | carry_s;
    // A zero magnitude never reports a negative sign.
    neg_next_s = sign_r & ((work_next_s != ZERO_DIGITS) | sticky_next_s);
  end

  // Control FSM and datapath registers; results load on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      mag_r      <= {WIDTH{1'b0}};
      work_r     <= ZERO_DIGITS;
      sign_r     <= 1'b0;
      sticky_r   <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bcd_r      <= ZERO_DIGITS;
      neg_r      <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            mag_r    <= mag_in_s;
            sign_r   <= sign_in_s;
            work_r   <= ZERO_DIGITS;
            sticky_r <= 1'b0;
            cnt_r    <= CW'(WIDTH);
            busy_r   <= 1'b1;
            state_r  <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          mag_r    <= mag_next_s;
          work_r   <= work_next_s;
          sticky_r <= sticky_next_s;
          cnt_r    <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r    <= DONE;
            done_r     <= 1'b1;
            bcd_r      <= sticky_next_s ? NINES : work_next_s;
            neg_r      <= neg_next_s;
            overflow_r <= sticky_next_s;
          end else begin
            state_r <= SHIFT;
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bcd      = bcd_r;
  assign bus.neg      = neg_r;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: three instances cover unsigned 5-digit,
// unsigned 4-digit (overflow) and signed 3-digit configurations.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt_a = 0;

  bin2bcd_seq_if #(.WIDTH(15), .DIGITS(5)) ia ();
  bin2bcd_seq_if #(.WIDTH(15), .DIGITS(4)) ib ();
  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) ic ();

  bin2bcd_seq #(.WIDTH(15), .DIGITS(5), .SIGNED(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  bin2bcd_seq #(.WIDTH(15), .DIGITS(4), .SIGNED(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  bin2bcd_seq #(.WIDTH(8),  .DIGITS(3), .SIGNED(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ia.done === 1'b1) done_cnt_a <= done_cnt_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return ia.done;
      1:       return ib.done;
      default: return ic.done;
    endcase
  endfunction

  // One-cycle start pulse; lat is the spec cycle number (accept = 0) in which done is seen.
  task automatic convert(input int sel, input logic [14:0] v, output int lat);
    @(negedge clk);
    case (sel)
      0:       begin ia.start = 1'b1; ia.binary = v; end
      1:       begin ib.start = 1'b1; ib.binary = v; end
      default: begin ic.start = 1'b1; ic.binary = v[7:0]; end
    endcase
    @(negedge clk);
    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
    ia.binary = 15'h0000; ib.binary = 15'h0000; ic.binary = 8'h00;
    lat = 1;
    while (done_of(sel) !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int gap;
    int low;
    int d0;
    rst_n = 1'b0;
    ia.start = 1'b0; ia.binary = 15'h0000;
    ib.start = 1'b0; ib.binary = 15'h0000;
    ic.start = 1'b0; ic.binary = 8'h00;
    #3;
    chk("reset_bcd",  ia.bcd, 32'h0);
    chk("reset_busy", ia.busy, 32'h0);
    chk("reset_done", ia.done, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    convert(0, 15'd12345, lat);
    chk("a12345_lat", lat, 32'd16);
    chk("a12345_bcd", ia.bcd, 32'h12345);
    chk("a12345_ovf", ia.overflow, 32'h0);
    chk("a12345_neg", ia.neg, 32'h0);
    @(negedge clk);
    chk("a12345_done_pulse", ia.done, 32'h0);

    // Back-to-back with start held high: 32767 then 0.
    @(negedge clk);
    ia.start = 1'b1; ia.binary = 15'd32767;
    @(negedge clk);
    ia.binary = 15'd0;
    lat = 1;
    while (ia.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_lat", lat, 32'd16);
    chk("b2b_first_bcd", ia.bcd, 32'h32767);
    gap = 0;
    low = 0;
    for (int i = 1; i <= 30 && gap == 0; i++) begin
      @(negedge clk);
      if (ia.busy !== 1'b1) low++;
      if (ia.done === 1'b1) gap = i;
    end
    ia.start = 1'b0;
    chk("b2b_gap", gap, 32'd17);
    chk("b2b_idle_cycles", low, 32'd1);
    chk("b2b_second_bcd", ia.bcd, 32'h00000);
    repeat (20) @(negedge clk);

    convert(1, 15'd12345, lat);
    chk("d4_ovf_flag", ib.overflow, 32'h1);
    chk("d4_ovf_bcd", ib.bcd, 32'h9999);
    convert(1, 15'd9999, lat);
    chk("d4_9999_flag", ib.overflow, 32'h0);
    chk("d4_9999_bcd", ib.bcd, 32'h9999);

    convert(2, 15'h0080, lat);
    chk("s8_80_lat", lat, 32'd9);
    chk("s8_80_neg", ic.neg, 32'h1);
    chk("s8_80_bcd", ic.bcd, 32'h128);
    convert(2, 15'h00FF, lat);
    chk("s8_ff_neg", ic.neg, 32'h1);
    chk("s8_ff_bcd", ic.bcd, 32'h001);
    convert(2, 15'h007F, lat);
    chk("s8_7f_neg", ic.neg, 32'h0);
    chk("s8_7f_bcd", ic.bcd, 32'h127);
    repeat (3) @(negedge clk);

    // A start pulse during SHIFT with a different operand must be ignored.
    d0 = done_cnt_a;
    ia.start = 1'b1; ia.binary = 15'd2468;
    @(negedge clk);
    ia.start = 1'b0; ia.binary = 15'd0;
    lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    ia.start = 1'b1; ia.binary = 15'd1357;
    @(negedge clk);
    lat++;
    ia.start = 1'b0; ia.binary = 15'd0;
    while (ia.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_lat", lat, 32'd16);
    chk("ign_bcd", ia.bcd, 32'h02468);
    repeat (20) @(negedge clk);
    chk("ign_one_done", done_cnt_a - d0, 32'd1);

    // Reset in cycle 7 of a conversion aborts it.
    convert(0, 15'd12345, lat);
    chk("pre_rst_bcd", ia.bcd, 32'h12345);
    @(negedge clk);
    ia.start = 1'b1; ia.binary = 15'd777;
    @(negedge clk);
    ia.start = 1'b0; ia.binary = 15'd0;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_bcd",  ia.bcd, 32'h0);
    chk("rst_neg",  ia.neg, 32'h0);
    chk("rst_ovf",  ia.overflow, 32'h0);
    chk("rst_busy", ia.busy, 32'h0);
    chk("rst_done", ia.done, 32'h0);
    d0 = done_cnt_a;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_done", done_cnt_a - d0, 32'd0);
    chk("rst_hold_bcd", ia.bcd, 32'h0);
    convert(0, 15'd4321, lat);
    chk("post_rst_lat", lat, 32'd16);
    chk("post_rst_bcd", ia.bcd, 32'h04321);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
